input_route_ctrl: RTL and testbench
===================================

# input_route_ctrl

Per-input-channel controller that sits directly downstream of the input FIFO buffer in each router port. It pops flits from the FIFO and decodes the head flit with XY routing. It then requests the chosen output port from the switch allocator and, once granted, streams the packet through a valid/ready interface until the tail flit has transferred. One instance exists per router input port.

## Interface
- DATA_WIDTH, 8, flit width; must equal the FIFO width.
- COORD_BITS, 2, bits per X/Y destination coordinate.
- CUR_X, 0, this router's X coordinate.
- CUR_Y, 0, this router's Y coordinate.
- clk  input  1  single clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_data  input  DATA_WIDTH  head-of-FIFO flit; valid while fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read  output  1  pop strobe to the FIFO (combinational).
- req  output  5  one-hot output-port request, bit order {W,S,E,N,L} = [4:0].
- grant  input  1  allocator grant for this input.
- out_valid  output  1  flit on out_data is valid.
- out_ready  input  1  downstream/crossbar accepts the flit.
- out_data  output  DATA_WIDTH  forwarded flit.
- pkt_cnt  output  16  count of packets fully forwarded; wraps modulo 2^16.
- drop_err  output  1  one-cycle pulse when a stray non-head flit is discarded in IDLE.

## Operation
- Flit type field: bits [DATA_WIDTH-1:DATA_WIDTH-2].
  - 2'b01 = head; 2'b00 = body; 2'b10 = tail; 2'b11 = single-flit (head+tail).
- Head destination fields: dst_x = [DATA_WIDTH-3 -: COORD_BITS], dst_y = next COORD_BITS below it.
- XY routing on unsigned compare, X first:
  - dst_x>CUR_X → E; dst_x<CUR_X → W.
  - Otherwise dst_y>CUR_Y → N; dst_y<CUR_Y → S.
  - Otherwise L.
- FSM states IDLE, WAIT_GNT, FWD.
- IDLE: req=0, out_valid=0.
  - fifo_empty=0 and type is head or single → latch route into port_reg and go to WAIT_GNT. The flit is not popped.
  - fifo_empty=0 and type is body or tail → fifo_read=1, drop_err=1 that cycle, stay in IDLE.
- WAIT_GNT: req=port_reg, no pop.
  - grant=1 → FWD next cycle.
  - grant=0 → hold indefinitely.
- FWD: req=port_reg held for the whole packet; grant is ignored.
  - out_valid = ~fifo_empty; out_data = fifo_data.
  - fifo_read = out_valid & out_ready.
  - On a transfer of a tail or single flit: pkt_cnt increments and the FSM returns to IDLE.
- fifo_read is never asserted while fifo_empty=1.

## Timing
- Reset values: state=IDLE, port_reg=0, req=0, out_valid=0, fifo_read=0, drop_err=0, pkt_cnt=0.
- Head appears at cycle 0 in IDLE → req asserted at cycle 1.
- grant sampled high at cycle k → FWD at k+1; head flit can transfer at k+1.
- Throughput in FWD: one flit per cycle while the FIFO is non-empty and out_ready=1.
- FIFO empty mid-packet: out_valid=0, state and req hold until data returns.
- out_ready=0: flit and FIFO pointer hold; out_data stays stable while out_valid=1.
- Tail transfers at cycle t:
  - req=0 and state=IDLE at t+1.
  - A following head can raise req at t+2 at the earliest.
- Single-flit packet: forwards in one FWD cycle, then returns to IDLE.
- Reset mid-packet: immediate return to IDLE with req=0. Remaining flits in the FIFO are treated as strays and dropped with drop_err until the next head.

## Structure
- Shared package noc_pkg holds:
  - flit type encodings (FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE);
  - port index constants (PORT_L..PORT_W) and NUM_PORTS=5;
  - FSM state encodings.
- Sub-module xy_route_comp: combinational; dst_x, dst_y, CUR_X, CUR_Y → 5-bit one-hot port. Reused by the local injection path.

## Test plan
- CUR=(1,1), head 8'b01_10_01_00 (dst 2,1), grant at cycle 3 → req=5'b00100 (E) from cycle 1; head out at cycle 4.
- Packet head/body/tail with out_ready=1 → 3 consecutive transfers; pkt_cnt 0→1; req=0 the cycle after the tail.
- out_ready toggled 1,0,0,1 mid-packet → out_data is stable while stalled; FIFO pops exactly 3 times total.
- Body flit 8'b00_xxxxxx in IDLE → fifo_read=1 and drop_err=1 for one cycle; req stays 0.
- Single-flit 8'b11_01_01_00 at CUR=(1,1) → req=5'b00001 (L); one transfer; pkt_cnt+1.
- rst asserted after the head transfers → req=0 and out_valid=0 immediately; next body and tail each raise drop_err.

Source files
------------

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
//   Shared NoC router definitions: flit type encodings, output port indices
//   and the input route controller FSM states. The flit-type helpers keep the
//   head/tail decode in one place so every consumer agrees on it.
// -----------------------------------------------------------------------------
package noc_pkg;

  // Flit type field encodings (top two bits of every flit).
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  // Output port indices inside the one-hot request vector {W,S,E,N,L}.
  localparam int NUM_PORTS = 5;
  localparam int PORT_L    = 0;
  localparam int PORT_N    = 1;
  localparam int PORT_E    = 2;
  localparam int PORT_S    = 3;
  localparam int PORT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_FWD      = 2'd2
  } route_state_e;

  // A flit that opens a packet (head or single-flit).
  function automatic logic is_head(input logic [1:0] flit_type);
    return (flit_type == FLIT_HEAD) || (flit_type == FLIT_SINGLE);
  endfunction

  // A flit that closes a packet (tail or single-flit).
  function automatic logic is_tail(input logic [1:0] flit_type);
    return (flit_type == FLIT_TAIL) || (flit_type == FLIT_SINGLE);
  endfunction

  // A flit that cannot start a packet; discarded when no packet is open.
  function automatic logic is_stray(input logic [1:0] flit_type);
    return (flit_type == FLIT_BODY) || (flit_type == FLIT_TAIL);
  endfunction

endpackage

// File: rtl/xy_route_comp.sv
// -----------------------------------------------------------------------------
// xy_route_comp
//   Combinational dimension-ordered (X first, then Y) route computation.
//   Unsigned compare of the destination against this router's coordinates.
//
//   dst_x, dst_y : destination coordinates from the head flit
//   port         : one-hot output port, bit order {W,S,E,N,L}
// -----------------------------------------------------------------------------
module xy_route_comp
  import noc_pkg::*;
#(
  parameter int COORD_BITS = 2,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0
) (
  input  logic [COORD_BITS-1:0] dst_x,
  input  logic [COORD_BITS-1:0] dst_y,
  output logic [NUM_PORTS-1:0]  port
);

  localparam logic [COORD_BITS-1:0] CX = COORD_BITS'(CUR_X);
  localparam logic [COORD_BITS-1:0] CY = COORD_BITS'(CUR_Y);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    port = '0;
    if (dst_x > CX)      port[PORT_E] = 1'b1;
    else if (dst_x < CX) port[PORT_W] = 1'b1;
    else if (dst_y > CY) port[PORT_N] = 1'b1;
    else if (dst_y < CY) port[PORT_S] = 1'b1;
    else                 port[PORT_L] = 1'b1;
  end

endmodule

// File: rtl/input_route_ctrl.sv
// -----------------------------------------------------------------------------
// input_route_ctrl
//   Per-input-port controller behind the input FIFO. Decodes the head flit
//   with XY routing, requests the output port from the switch allocator and,
//   once granted, streams the packet over valid/ready until the tail leaves.
//
//   clk, rst   : clock, asynchronous active-high reset
//   fifo_data  : head-of-FIFO flit, valid while fifo_empty=0
//   fifo_empty : FIFO empty flag
//   fifo_read  : combinational pop strobe to the FIFO
//   req        : one-hot output port request {W,S,E,N,L}
//   grant      : allocator grant for this input
//   out_valid, out_ready, out_data : forwarded flit stream
//   pkt_cnt    : packets fully forwarded (wraps)
//   drop_err   : one-cycle pulse when a stray body/tail is discarded
// -----------------------------------------------------------------------------
module input_route_ctrl
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COORD_BITS = 2,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  output logic [NUM_PORTS-1:0]  req,
  input  logic                  grant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [15:0]           pkt_cnt,
  output logic                  drop_err
);

  route_state_e          state, state_nxt;
  logic [NUM_PORTS-1:0]  port_reg;
  logic [NUM_PORTS-1:0]  route_port;
  logic                  latch_route;
  logic                  pkt_done;

  logic [1:0]            flit_type;
  logic [COORD_BITS-1:0] dst_x, dst_y;

  assign flit_type = fifo_data[DATA_WIDTH-1 -: 2];
  assign dst_x     = fifo_data[DATA_WIDTH-3 -: COORD_BITS];
  assign dst_y     = fifo_data[DATA_WIDTH-3-COORD_BITS -: COORD_BITS];
  assign out_data  = fifo_data;

  xy_route_comp #(
    .COORD_BITS (COORD_BITS),
    .CUR_X      (CUR_X),
    .CUR_Y      (CUR_Y)
  ) u_xy_route (
    .dst_x (dst_x),
    .dst_y (dst_y),
    .port  (route_port)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      port_reg <= '0;
      pkt_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (latch_route) port_reg <= route_port;
      if (pkt_done)    pkt_cnt  <= pkt_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    req         = '0;
    out_valid   = 1'b0;
    fifo_read   = 1'b0;
    drop_err    = 1'b0;
    latch_route = 1'b0;
    pkt_done    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // The head stays in the FIFO until it is actually forwarded. Strays
        // are popped, but not while reset is held, so the reset outputs are
        // quiet even with a stray sitting at the FIFO head.
        if (!rst && !fifo_empty) begin
          if (is_head(flit_type)) begin
            latch_route = 1'b1;
            state_nxt   = ST_WAIT_GNT;
          end else if (is_stray(flit_type)) begin
            fifo_read = 1'b1;
            drop_err  = 1'b1;
          end
        end
      end

      ST_WAIT_GNT: begin
        req = port_reg;
        if (grant) state_nxt = ST_FWD;
      end

      ST_FWD: begin
        // The port stays claimed for the whole packet; grant is not rechecked.
        req       = port_reg;
        out_valid = !fifo_empty;
        fifo_read = out_valid && out_ready;
        if (fifo_read && is_tail(flit_type)) begin
          pkt_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_input_route_ctrl.sv
module tb_input_route_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_read;
  logic [4:0]    req;
  logic          grant;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [15:0]   pkt_cnt;
  logic          drop_err;

  input_route_ctrl #(
    .DATA_WIDTH (DW),
    .COORD_BITS (2),
    .CUR_X      (1),
    .CUR_Y      (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .req        (req),
    .grant      (grant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .pkt_cnt    (pkt_cnt),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment FIFO contents and packets not yet written into it.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] pend[$];
  int            pops = 0;

  // Reference model: packet progress expressed as "no packet / asking /
  // streaming", the port the packet wants, and completed packet count.
  int            phase = 0;
  logic [4:0]    m_port = '0;
  logic [15:0]   m_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? '0 : fq[0];
  endtask

  task automatic push(input logic [DW-1:0] f);
    fq.push_back(f);
    refresh();
  endtask

  // XY routing at (1,1): {W,S,E,N,L} one-hot.
  function automatic logic [4:0] route_of(input logic [DW-1:0] f);
    logic [1:0] dx, dy;
    dx = f[5:4];
    dy = f[3:2];
    if (dx > 2'd1) return 5'b00100;
    if (dx < 2'd1) return 5'b10000;
    if (dy > 2'd1) return 5'b00010;
    if (dy < 2'd1) return 5'b01000;
    return 5'b00001;
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model,
  // clock, then let the FIFO act on the DUT's pop and advance the model.
  task automatic step(input logic g, input logic r);
    logic       has, dut_rd;
    logic [1:0] t;
    logic [4:0] e_req;
    logic       e_val, e_rd, e_drop;
    grant     = g;
    out_ready = r;
    #1;
    has    = (fq.size() != 0);
    t      = has ? fq[0][7:6] : 2'b00;
    e_req  = '0;
    e_val  = 1'b0;
    e_rd   = 1'b0;
    e_drop = 1'b0;
    if (phase == 0) begin
      if (has && (t == 2'b00 || t == 2'b10)) begin
        e_rd   = 1'b1;
        e_drop = 1'b1;
      end
    end else if (phase == 1) begin
      e_req = m_port;
    end else begin
      e_req = m_port;
      e_val = has;
      e_rd  = has && r;
    end
    check("req", 32'(req), 32'(e_req));
    check("out_valid", 32'(out_valid), 32'(e_val));
    check("fifo_read", 32'(fifo_read), 32'(e_rd));
    check("drop_err", 32'(drop_err), 32'(e_drop));
    check("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
    if (e_val) check("out_data", 32'(out_data), 32'(fq[0]));
    dut_rd = fifo_read;
    @(posedge clk);
    #1;
    if (phase == 0 && has && (t == 2'b01 || t == 2'b11)) begin
      phase  = 1;
      m_port = route_of(fq[0]);
    end else if (phase == 1 && g) begin
      phase = 2;
    end else if (phase == 2 && e_rd && (t == 2'b10 || t == 2'b11)) begin
      phase = 0;
      m_cnt = m_cnt + 16'd1;
    end
    if (dut_rd && fq.size() != 0) begin
      void'(fq.pop_front());
      pops++;
    end
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_req", 32'(req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fifo_read", 32'(fifo_read), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    phase = 0;
    m_cnt = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int p0, budget;
    logic [DW-1:0] f;
    rst       = 1'b1;
    grant     = 1'b0;
    out_ready = 1'b0;
    refresh();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Head to (2,1): east; granted at cycle 3, head out at cycle 4.
    push(8'b01_10_01_00);
    push(8'b00_10_01_01);
    push(8'b10_10_01_10);
    step(1'b0, 1'b1);
    check("plan_req_E", 32'(req), 32'b00100);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("plan_head_valid", 32'(out_valid), 32'd1);
    check("plan_head_data", 32'(out_data), 32'h64);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("plan_cnt_1", 32'(pkt_cnt), 32'd1);
    check("plan_req_off", 32'(req), 32'd0);

    // Stall mid-packet: destination (0,2) routes west.
    p0 = pops;
    push(8'b01_00_10_11);
    push(8'b00_11_00_11);
    push(8'b10_01_01_01);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("stall_data_1", 32'(out_data), 32'h33);
    step(1'b0, 1'b0);
    check("stall_data_2", 32'(out_data), 32'h33);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("stall_pops", 32'(pops - p0), 32'd3);

    // Stray body in IDLE.
    push(8'b00_101010);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Single-flit to self: local port.
    push(8'b11_01_01_00);
    step(1'b0, 1'b1);
    check("single_req_L", 32'(req), 32'b00001);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("single_cnt", 32'(pkt_cnt), 32'd3);
    step(1'b0, 1'b1);

    // Reset after the head leaves: rest of the packet becomes strays.
    push(8'b01_01_00_01);
    push(8'b00_000001);
    push(8'b10_000010);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Random packets and strays, flits trickling in, random grant/ready.
    for (int n = 0; n < 40; n++) begin
      int kind, nb;
      kind = $urandom_range(0, 5);
      f = 8'($urandom);
      if (kind == 0) begin
        f[7] = 1'b0; f[6] = 1'b0;
        pend.push_back(f);
      end else if (kind == 1) begin
        f[7] = 1'b1; f[6] = 1'b1;
        pend.push_back(f);
      end else begin
        f[7] = 1'b0; f[6] = 1'b1;
        pend.push_back(f);
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) begin
          f = 8'($urandom);
          f[7] = 1'b0; f[6] = 1'b0;
          pend.push_back(f);
        end
        f = 8'($urandom);
        f[7] = 1'b1; f[6] = 1'b0;
        pend.push_back(f);
      end
      budget = 0;
      while ((pend.size() != 0 || fq.size() != 0 || phase != 0) && budget < 300) begin
        if (pend.size() != 0 && $urandom_range(0, 2) != 0) push(pend.pop_front());
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        budget++;
      end
      if (budget >= 300) begin
        check("rand_budget", 32'(budget), 32'd0);
        pend.delete();
      end
    end
    check("final_cnt", 32'(pkt_cnt), 32'(m_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
